// File: rtl/noc_ni_pkg.sv
// Shared definitions for the synchronous-to-asynchronous NI transmitter.
//   state_t   : transmit FSM states
//   enc_1of4  : 2-bit value to 1-of-4 rail code (bit v set for value v)
package noc_ni_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_DRTZ = 3'd2,
    S_EOF  = 3'd3,
    S_ERTZ = 3'd4
  } state_t;

  function automatic logic [3:0] enc_1of4(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

endpackage

// File: rtl/ni_sync.sv
// Multi-stage level synchroniser with synchronous active-high reset.
//   clk : sampling clock
//   rst : synchronous reset, clears all stages
//   d_i : asynchronous input level
//   q_o : synchronised level, SYNC edges behind d_i
module ni_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC-1];

endmodule

// File: rtl/ni_tx_1of4.sv
// Synchronous-to-asynchronous NI transmitter. Buffers a valid/ready flit stream in a
// small FIFO and sends each flit as a 4-phase RTZ token of 1-of-4 sub-channels, followed
// by a separate EOF token on o4 after a tail flit.
//   clk, rst          : clock, synchronous active-high reset
//   in_data/in_tail   : flit payload and end-of-frame flag
//   in_valid/in_ready : push handshake (push when both high)
//   o0..o3            : 1-of-4 data rails, one bit per sub-channel
//   o4                : EOF rail
//   ack               : asynchronous acknowledge from the crossbar
//   busy              : FIFO holds flits or a token is in flight
//
// state  | meaning
// S_IDLE | rails low; start a token when FIFO not empty and ack_s low
// S_DATA | data rails carry the flit code; wait for ack_s high
// S_DRTZ | rails low; wait for ack_s low, then EOF token if the flit was a tail
// S_EOF  | o4 high; wait for ack_s high
// S_ERTZ | rails low; wait for ack_s low
module ni_tx_1of4
  import noc_ni_pkg::*;
#(
  parameter  int DW   = 8,
  parameter  int FD   = 2,
  parameter  int SYNC = 2,
  localparam int SCN  = DW / 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  in_data,
  input  logic           in_tail,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [SCN-1:0] o0,
  output logic [SCN-1:0] o1,
  output logic [SCN-1:0] o2,
  output logic [SCN-1:0] o3,
  output logic           o4,
  input  logic           ack,
  output logic           busy
);

  localparam int AW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);

  logic [DW-1:0] fifo_data_q [FD];
  logic [FD-1:0] fifo_tail_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;
  logic [DW-1:0] head_data;
  logic          head_tail;

  logic          ack_s;

  state_t        state_q, state_d;
  logic          tail_q, tail_d;
  logic [SCN-1:0] r0_q, r1_q, r2_q, r3_q;
  logic [SCN-1:0] r0_d, r1_d, r2_d, r3_d;
  logic          o4_q, o4_d;
  logic [3:0]    code;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign full     = (count_q == CW'(FD));
  assign empty    = (count_q == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;

  assign head_data = fifo_data_q[rd_ptr_q];
  assign head_tail = fifo_tail_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= in_data;
      fifo_tail_q[wr_ptr_q] <= in_tail;
    end
  end

  ni_sync #(.SYNC(SYNC)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack),
    .q_o (ack_s)
  );

  always_comb begin
    state_d = state_q;
    tail_d  = tail_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    o4_d    = o4_q;
    pop     = 1'b0;
    code    = '0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !ack_s) begin
          pop    = 1'b1;
          tail_d = head_tail;
          for (int k = 0; k < SCN; k++) begin
            code    = enc_1of4(head_data[2*k +: 2]);
            r0_d[k] = code[0];
            r1_d[k] = code[1];
            r2_d[k] = code[2];
            r3_d[k] = code[3];
          end
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (ack_s) begin
          r0_d    = '0;
          r1_d    = '0;
          r2_d    = '0;
          r3_d    = '0;
          state_d = S_DRTZ;
        end
      end
      S_DRTZ: begin
        if (!ack_s) begin
          if (tail_q) begin
            o4_d    = 1'b1;
            state_d = S_EOF;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_EOF: begin
        if (ack_s) begin
          o4_d    = 1'b0;
          state_d = S_ERTZ;
        end
      end
      S_ERTZ: begin
        if (!ack_s) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tail_d  = 1'b0;
        r0_d    = '0;
        r1_d    = '0;
        r2_d    = '0;
        r3_d    = '0;
        o4_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tail_q  <= 1'b0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      o4_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tail_q  <= tail_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      o4_q    <= o4_d;
    end
  end

  assign o0   = r0_q;
  assign o1   = r1_q;
  assign o2   = r2_q;
  assign o3   = r3_q;
  assign o4   = o4_q;
  assign busy = !empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_ni_tx_1of4.sv
// Directed bench for ni_tx_1of4. Rails are viewed as {o4,o3,o2,o1,o0} (17 bits).
module tb_ni_tx_1of4;

  localparam int DW   = 8;
  localparam int SCN  = DW / 2;
  localparam int FD   = 2;
  localparam int SYNC = 2;

  logic           clk;
  logic           rst;
  logic [DW-1:0]  in_data;
  logic           in_tail;
  logic           in_valid;
  logic           in_ready;
  logic [SCN-1:0] o0, o1, o2, o3;
  logic           o4;
  logic           ack;
  logic           busy;

  logic [4*SCN:0] rails_w;
  assign rails_w = {o4, o3, o2, o1, o0};

  ni_tx_1of4 #(.DW(DW), .FD(FD), .SYNC(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_tail  (in_tail),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .o0       (o0),
    .o1       (o1),
    .o2       (o2),
    .o3       (o3),
    .o4       (o4),
    .ack      (ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ack driver: manual level, or a responder that echoes rail activity 3 cycles late.
  logic       auto_ack = 1'b0;
  logic       man_ack  = 1'b0;
  logic [2:0] dly      = '0;
  initial begin
    ack = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      ack = auto_ack ? dly[2] : man_ack;
      dly = {dly[1:0], |rails_w};
    end
  end

  // Protocol monitor and token recorder, sampling 2 time units after each rising edge.
  logic [4*SCN:0]  tok_q[$];
  logic [SYNC-1:0] msync      = '0;
  logic            prev_acks  = 1'b0;
  logic [4*SCN:0]  prev_rails = '0;
  int              proto_err  = 0;
  int              stable_err = 0;
  initial begin
    logic ok;
    forever begin
      @(posedge clk);
      #2;
      if (rst) msync = '0;
      else     msync = {msync[SYNC-2:0], ack};
      ok = 1'b1;
      for (int k = 0; k < SCN; k++)
        if ($countones({o3[k], o2[k], o1[k], o0[k]}) > 1) ok = 1'b0;
      if (o4 && (|{o3, o2, o1, o0})) ok = 1'b0;
      if (!ok) proto_err++;
      if (!rst && prev_rails != '0 && !prev_acks && rails_w != prev_rails) stable_err++;
      if (!rst && rails_w != '0 && prev_rails == '0) tok_q.push_back(rails_w);
      prev_acks  = msync[SYNC-1];
      prev_rails = rails_w;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_flit(input logic [DW-1:0] d, input logic t);
    int n;
    n = 0;
    in_data  = d;
    in_tail  = t;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("push_rdy", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, busy, 1'b0);
  endtask

  task automatic wait_rtz(input string tag);
    int n;
    n = 0;
    while (rails_w != '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, rails_w, 17'h0);
  endtask

  localparam logic [16:0] TOK_E4  = 17'h08421;
  localparam logic [16:0] TOK_00  = 17'h0000F;
  localparam logic [16:0] TOK_FF  = 17'h0F000;
  localparam logic [16:0] TOK_EOF = 17'h10000;
  localparam logic [16:0] TOK_A1  = 17'h00C12;
  localparam logic [16:0] TOK_B2  = 17'h04902;
  localparam logic [16:0] TOK_C3  = 17'h09006;

  int base;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_tail  = 1'b0;

    // reset state
    step(2);
    check_eq("rst_rdy", in_ready, 1'b0);
    check_eq("rst_rails", rails_w, 17'h0);
    check_eq("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step(1);
    check_eq("rdy_after_rst", in_ready, 1'b1);

    // single flit with 3-cycle ack responder
    auto_ack = 1'b1;
    base = tok_q.size();
    push_flit(8'hE4, 1'b0);
    check_eq("lat_pre", rails_w, 17'h0);
    step(1);
    check_eq("e4_code", rails_w, TOK_E4);
    check_eq("e4_busy", busy, 1'b1);
    wait_rtz("e4_rtz");
    wait_idle("e4_idle");
    check_eq("e4_ntok", tok_q.size() - base, 1);
    check_eq("e4_tok", tok_q[base], TOK_E4);

    // frame: two flits then EOF
    base = tok_q.size();
    push_flit(8'h00, 1'b0);
    push_flit(8'hFF, 1'b1);
    wait_idle("frame_idle");
    check_eq("frame_ntok", tok_q.size() - base, 3);
    check_eq("frame_tok0", tok_q[base], TOK_00);
    check_eq("frame_tok1", tok_q[base+1], TOK_FF);
    check_eq("frame_eof", tok_q[base+2], TOK_EOF);

    // backpressure: ack held low, three flits fill FSM + FIFO
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    step(4);
    base = tok_q.size();
    push_flit(8'hA1, 1'b0);
    push_flit(8'hB2, 1'b0);
    push_flit(8'hC3, 1'b0);
    check_eq("bp_full", in_ready, 1'b0);
    check_eq("bp_busy", busy, 1'b1);
    check_eq("bp_head", rails_w, TOK_A1);
    step(5);
    check_eq("bp_full_hold", in_ready, 1'b0);
    check_eq("bp_head_hold", rails_w, TOK_A1);
    auto_ack = 1'b1;
    wait_idle("bp_idle");
    check_eq("bp_ntok", tok_q.size() - base, 3);
    check_eq("bp_tok0", tok_q[base], TOK_A1);
    check_eq("bp_tok1", tok_q[base+1], TOK_B2);
    check_eq("bp_tok2", tok_q[base+2], TOK_C3);
    check_eq("bp_rdy", in_ready, 1'b1);

    // stale ack at reset release
    auto_ack = 1'b0;
    man_ack  = 1'b1;
    rst      = 1'b1;
    step(2);
    rst = 1'b0;
    step(4);
    push_flit(8'hE4, 1'b0);
    step(3);
    check_eq("stale_hold", rails_w, 17'h0);
    check_eq("stale_busy", busy, 1'b1);
    man_ack = 1'b0;
    step(2);
    check_eq("stale_m2", rails_w, 17'h0);
    step(1);
    check_eq("stale_go", rails_w, TOK_E4);
    // rails fall SYNC+1 edges after ack rises
    man_ack = 1'b1;
    step(2);
    check_eq("fall_hold", rails_w, TOK_E4);
    step(1);
    check_eq("fall_sync", rails_w, 17'h0);
    man_ack = 1'b0;
    wait_idle("stale_idle");

    // reset mid-token
    step(3);
    push_flit(8'hC3, 1'b0);
    push_flit(8'hA1, 1'b1);
    check_eq("mid_tok", rails_w, TOK_C3);
    rst = 1'b1;
    step(1);
    check_eq("mid_rst_rails", rails_w, 17'h0);
    check_eq("mid_rst_rdy", in_ready, 1'b0);
    rst = 1'b0;
    step(1);
    check_eq("mid_busy", busy, 1'b0);
    check_eq("mid_rdy", in_ready, 1'b1);
    step(4);
    check_eq("mid_empty_rails", rails_w, 17'h0);
    check_eq("mid_empty_busy", busy, 1'b0);

    // protocol properties observed throughout
    check_eq("proto_viol", proto_err, 0);
    check_eq("stable_viol", stable_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
